// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle fetch/decode/execute control FSM for Simple_CPU.
// Optional single-step mode: define SINGLE_STEP_EN to add the Step input and PAUSE state.
module alu_sequencer #(
    parameter int PC_WIDTH            = 8,
    parameter int WIDTH_DATA_LENGTH   = 8,
    parameter int WIDTH_ALUSEL_LENGTH = 4
) (
    input  logic                           Clk,
    input  logic                           Reset_n,
`ifdef SINGLE_STEP_EN
    input  logic                           Step,
`endif
    input  logic [WIDTH_DATA_LENGTH-1:0]   InstrData,
    input  logic                           InstrAck,
    input  logic                           CF,
    input  logic                           ZF,
    output logic [PC_WIDTH-1:0]            PC,
    output logic                           InstrReq,
    output logic [1:0]                     RdAddr,
    output logic [1:0]                     RsAddr,
    output logic                           RegWrite,
    output logic                           ImmSel,
    output logic [WIDTH_DATA_LENGTH-1:0]   Imm,
    output logic [WIDTH_ALUSEL_LENGTH-1:0] ALUSel,
    output logic                           WriteCZ,
    output logic                           Halted
);

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_FETCH_IMM,
        S_LOAD_IMM,
`ifdef SINGLE_STEP_EN
        S_PAUSE,
`endif
        S_HALT
    } state_t;

`ifdef SINGLE_STEP_EN
    localparam state_t S_NEXT = S_PAUSE;
`else
    localparam state_t S_NEXT = S_FETCH;
`endif

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_MOV = 4'h1;
    localparam logic [3:0] OP_SHL = 4'h9;
    localparam logic [3:0] OP_LDI = 4'hA;
    localparam logic [3:0] OP_HLT = 4'hB;
    localparam logic [3:0] OP_JMP = 4'hC;
    localparam logic [3:0] OP_JZ  = 4'hD;
    localparam logic [3:0] OP_JC  = 4'hE;
    localparam logic [3:0] OP_RSV = 4'hF;

    state_t                         r_state;
    logic [PC_WIDTH-1:0]            r_pc;
    logic [WIDTH_DATA_LENGTH-1:0]   r_ir;
    logic [WIDTH_DATA_LENGTH-1:0]   r_imm;
    logic                           r_run;

    state_t                         w_next_state;
    logic [PC_WIDTH-1:0]            w_next_pc;
    logic [WIDTH_DATA_LENGTH-1:0]   w_next_ir;
    logic [WIDTH_DATA_LENGTH-1:0]   w_next_imm;
    logic [3:0]                     w_op;
    logic [PC_WIDTH-1:0]            w_pc_inc;
    logic [PC_WIDTH-1:0]            w_target;
    logic                           w_is_nop;
    logic                           w_is_alu;
    logic                           w_is_imm;
    logic                           w_is_halt;
    logic                           w_taken;
    logic                           w_req;
    logic                           w_regwrite;
    logic                           w_immsel;
    logic [WIDTH_ALUSEL_LENGTH-1:0] w_alusel;
    logic                           w_writecz;
    logic                           w_halted;

    assign w_op      = r_ir[7:4];
    assign w_pc_inc  = r_pc + PC_WIDTH'(1);
    assign w_target  = PC_WIDTH'(InstrData);
    assign w_is_nop  = (w_op == OP_NOP);
    assign w_is_alu  = (w_op >= OP_MOV) && (w_op <= OP_SHL);
    assign w_is_imm  = (w_op == OP_LDI) || (w_op == OP_JMP) ||
                       (w_op == OP_JZ)  || (w_op == OP_JC);
    assign w_is_halt = (w_op == OP_HLT) || (w_op == OP_RSV);
    assign w_taken   = (w_op == OP_JMP) ||
                       ((w_op == OP_JZ) && ZF) ||
                       ((w_op == OP_JC) && CF);

    // Hold the fetch request off until the first clock after reset release.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_run <= 1'b0;
        end else begin
            r_run <= 1'b1;
        end
    end

    // State, PC, instruction and immediate registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state <= S_NEXT;
            r_pc    <= '0;
            r_ir    <= '0;
            r_imm   <= '0;
        end else begin
            r_state <= w_next_state;
            r_pc    <= w_next_pc;
            r_ir    <= w_next_ir;
            r_imm   <= w_next_imm;
        end
    end

    // Next-state, register updates and control outputs from registered state.
    always_comb begin
        w_next_state = r_state;
        w_next_pc    = r_pc;
        w_next_ir    = r_ir;
        w_next_imm   = r_imm;
        w_req        = 1'b0;
        w_regwrite   = 1'b0;
        w_immsel     = 1'b0;
        w_alusel     = '0;
        w_writecz    = 1'b0;
        w_halted     = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_req = r_run;
                if (r_run && InstrAck) begin
                    w_next_ir    = InstrData;
                    w_next_pc    = w_pc_inc;
                    w_next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                unique case (1'b1)
                    w_is_nop:  w_next_state = S_NEXT;
                    w_is_alu:  w_next_state = S_EXEC;
                    w_is_imm:  w_next_state = S_FETCH_IMM;
                    w_is_halt: w_next_state = S_HALT;
                endcase
            end
            S_EXEC: begin
                w_alusel     = WIDTH_ALUSEL_LENGTH'(w_op);
                w_regwrite   = 1'b1;
                w_writecz    = (w_op != OP_MOV);
                w_next_state = S_NEXT;
            end
            S_FETCH_IMM: begin
                w_req = r_run;
                if (r_run && InstrAck) begin
                    w_next_imm = InstrData;
                    if (w_op == OP_LDI) begin
                        w_next_pc    = w_pc_inc;
                        w_next_state = S_LOAD_IMM;
                    end else begin
                        w_next_pc    = w_taken ? w_target : w_pc_inc;
                        w_next_state = S_NEXT;
                    end
                end
            end
            S_LOAD_IMM: begin
                w_regwrite   = 1'b1;
                w_immsel     = 1'b1;
                w_next_state = S_NEXT;
            end
`ifdef SINGLE_STEP_EN
            S_PAUSE: begin
                if (Step) begin
                    w_next_state = S_FETCH;
                end
            end
`endif
            S_HALT: begin
                w_halted = 1'b1;
            end
            default: begin
                w_next_state = S_NEXT;
            end
        endcase
    end

    assign PC       = r_pc;
    assign InstrReq = w_req;
    assign RdAddr   = r_ir[3:2];
    assign RsAddr   = r_ir[1:0];
    assign Imm      = r_imm;
    assign RegWrite = w_regwrite;
    assign ImmSel   = w_immsel;
    assign ALUSel   = w_alusel;
    assign WriteCZ  = w_writecz;
    assign Halted   = w_halted;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: scoreboard bench with an instruction-level reference model.
// A memory responder feeds bytes; a monitor checks fetch addresses, writes and timing.
module tb_alu_sequencer;

    typedef struct packed {
        logic [1:0] rd;
        logic [1:0] rs;
        logic       immsel;
        logic [7:0] imm;
        logic [3:0] alusel;
        logic       wcz;
    } wr_t;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [7:0] InstrData;
    logic       InstrAck;
    logic       CF;
    logic       ZF;
    logic [7:0] PC;
    logic       InstrReq;
    logic [1:0] RdAddr;
    logic [1:0] RsAddr;
    logic       RegWrite;
    logic       ImmSel;
    logic [7:0] Imm;
    logic [3:0] ALUSel;
    logic       WriteCZ;
    logic       Halted;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [256];
    logic [7:0] m_pc;
    logic       m_need_imm;
    logic       m_halted;
    logic [3:0] m_op;
    logic [1:0] m_rd;
    logic [1:0] m_rs;
    int         m_count;
    int         m_limit;
    bit         phase_a;
    bit         stall_imm;

    logic [7:0] exp_pc [$];
    wr_t        exp_wr [$];
    int         exp_gap [$];

    alu_sequencer dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .InstrData (InstrData),
        .InstrAck  (InstrAck),
        .CF        (CF),
        .ZF        (ZF),
        .PC        (PC),
        .InstrReq  (InstrReq),
        .RdAddr    (RdAddr),
        .RsAddr    (RsAddr),
        .RegWrite  (RegWrite),
        .ImmSel    (ImmSel),
        .Imm       (Imm),
        .ALUSel    (ALUSel),
        .WriteCZ   (WriteCZ),
        .Halted    (Halted)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_pc       = 8'h00;
        m_need_imm = 1'b0;
        m_halted   = 1'b0;
        m_count    = 0;
        exp_pc.delete();
        exp_wr.delete();
        exp_gap.delete();
    endtask

    // Instruction-level model: consumes one memory byte per handshake.
    task automatic serve();
        logic [7:0] b;
        wr_t        w;
        bit         taken;
        if (!m_need_imm) begin
            if (m_count == m_limit) mem[m_pc] = 8'hB0;
            b = mem[m_pc];
            exp_pc.push_back(m_pc);
            m_pc = m_pc + 8'd1;
            CF = 1'($urandom);
            ZF = phase_a ? (m_count == 2) : 1'($urandom);
            m_count++;
            m_op = b[7:4];
            m_rd = b[3:2];
            m_rs = b[1:0];
            if (m_op == 4'h0) begin
                exp_gap.push_back(2);
            end else if (m_op <= 4'h9) begin
                w = '{rd: m_rd, rs: m_rs, immsel: 1'b0, imm: 8'h00,
                      alusel: m_op, wcz: (m_op != 4'h1)};
                exp_wr.push_back(w);
                exp_gap.push_back(3);
            end else if (m_op == 4'hB || m_op == 4'hF) begin
                m_halted = 1'b1;
                exp_gap.push_back(-1);
            end else begin
                m_need_imm = 1'b1;
                exp_gap.push_back(2);
            end
        end else begin
            b = mem[m_pc];
            exp_pc.push_back(m_pc);
            m_pc = m_pc + 8'd1;
            m_need_imm = 1'b0;
            if (m_op == 4'hA) begin
                w = '{rd: m_rd, rs: m_rs, immsel: 1'b1, imm: b,
                      alusel: 4'h0, wcz: 1'b0};
                exp_wr.push_back(w);
                exp_gap.push_back(2);
            end else begin
                taken = (m_op == 4'hC) || (m_op == 4'hD && ZF) ||
                        (m_op == 4'hE && CF);
                if (taken) m_pc = b;
                exp_gap.push_back(1);
            end
        end
        InstrData = mem[PC];
    endtask

    // Memory responder: acks requests after a delay, sprays stray acks when idle.
    initial begin
        int  d;
        bit  ok;
        logic [7:0] pc0;
        InstrAck  = 1'b0;
        InstrData = 8'h00;
        forever begin
            @(posedge Clk);
            #1;
            InstrAck = 1'b0;
            if (Reset_n && InstrReq && !(stall_imm && m_need_imm)) begin
                d   = phase_a ? ((PC == 8'hFF) ? 3 : 0) : int'($urandom_range(0, 2));
                pc0 = PC;
                ok  = 1'b1;
                for (int k = 0; k < d && ok; k++) begin
                    @(posedge Clk);
                    #1;
                    if (!Reset_n) begin
                        ok = 1'b0;
                    end else begin
                        checks++;
                        if (!InstrReq || PC !== pc0) begin
                            errors++;
                            $display("FAIL hold: req=%0b pc=%0h expected req=1 pc=%0h",
                                     InstrReq, PC, pc0);
                            ok = 1'b0;
                        end
                    end
                end
                if (ok) begin
                    serve();
                    InstrAck = 1'b1;
                end
            end else if (Reset_n && !InstrReq && $urandom_range(0, 3) == 0) begin
                InstrData = 8'($urandom);
                InstrAck  = 1'b1;
            end
        end
    end

    // Monitor: fetch address, register-write and request-gap scoreboard.
    initial begin
        int  cyc = 0;
        int  ack_cyc = 0;
        int  pending = -1;
        bit  prev_req = 1'b0;
        bit  prev_hs = 1'b0;
        bit  hs;
        wr_t got;
        wr_t want;
        forever begin
            @(negedge Clk);
            cyc++;
            if (!Reset_n) begin
                pending  = -1;
                prev_req = 1'b0;
                prev_hs  = 1'b0;
            end else begin
                hs = InstrReq && InstrAck;
                if (InstrReq && (!prev_req || prev_hs) && pending >= 0) begin
                    chk("req_gap", cyc - ack_cyc, pending);
                    pending = -1;
                end
                if (hs) begin
                    if (exp_pc.size() == 0) begin
                        chk("unexpected_fetch", PC, 32'hFFFF);
                    end else begin
                        chk("fetch_pc", PC, exp_pc.pop_front());
                        pending = exp_gap.pop_front();
                    end
                    ack_cyc = cyc;
                end
                got = '{rd: RdAddr, rs: RsAddr, immsel: ImmSel,
                        imm: ImmSel ? Imm : 8'h00, alusel: ALUSel, wcz: WriteCZ};
                if (RegWrite) begin
                    if (exp_wr.size() == 0) begin
                        chk("unexpected_write", 32'(got), 32'hFFFF_FFFF);
                    end else begin
                        want = exp_wr.pop_front();
                        chk("write", 32'(got), 32'(want));
                    end
                end else begin
                    chk("idle_ctrl", {ALUSel, WriteCZ, ImmSel}, 6'h0);
                end
                prev_req = InstrReq;
                prev_hs  = hs;
            end
        end
    end

    task automatic wait_halt(input int lim, input string tag);
        bit seen = 1'b0;
        bit ok = 1'b1;
        for (int i = 0; i < lim && !seen; i++) begin
            @(negedge Clk);
            seen = Halted;
        end
        chk({tag, "_halted"}, Halted, 1'b1);
        chk({tag, "_pc"}, PC, m_pc);
        chk({tag, "_fetch_q"}, exp_pc.size(), 0);
        chk({tag, "_write_q"}, exp_wr.size(), 0);
        for (int i = 0; i < 16; i++) begin
            @(negedge Clk);
            if (InstrReq || !Halted) ok = 1'b0;
        end
        chk({tag, "_halt_sticky"}, ok, 1'b1);
    endtask

    initial begin
        bit reached;
        Reset_n   = 1'b0;
        CF        = 1'b0;
        ZF        = 1'b0;
        stall_imm = 1'b0;
        phase_a   = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = 8'h00;
        mem[8'h00] = 8'h41;
        mem[8'h01] = 8'hA8;
        mem[8'h02] = 8'h5A;
        mem[8'h03] = 8'hD0;
        mem[8'h04] = 8'h10;
        mem[8'h10] = 8'hD0;
        mem[8'h11] = 8'h20;
        mem[8'h12] = 8'h1C;
        mem[8'h13] = 8'hC0;
        mem[8'h14] = 8'hFF;
        model_reset();
        m_limit = 7;
        repeat (3) @(negedge Clk);
        chk("rst_pc", PC, 8'h00);
        chk("rst_req", InstrReq, 1'b0);
        chk("rst_halted", Halted, 1'b0);
        chk("rst_ctrl", {RegWrite, ImmSel, ALUSel, WriteCZ}, 7'h0);
        chk("rst_ir_imm", {RdAddr, RsAddr, Imm}, 12'h000);
        #2 Reset_n = 1'b1;
        #1 chk("req_at_release", InstrReq, 1'b0);
        wait_halt(500, "A");

        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        chk("halt_rst_halted", Halted, 1'b0);
        chk("halt_rst_pc", PC, 8'h00);
        chk("halt_rst_req", InstrReq, 1'b0);
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'($urandom);
            if (mem[i][7:4] == 4'hB || mem[i][7:4] == 4'hF) mem[i][7] = 1'b0;
        end
        model_reset();
        phase_a = 1'b0;
        m_limit = 300;
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        wait_halt(20000, "B");

        @(posedge Clk);
        #3 Reset_n = 1'b0;
        mem[8'h00] = 8'hC0;
        mem[8'h01] = 8'h05;
        mem[8'h05] = 8'h00;
        model_reset();
        m_limit   = 2;
        stall_imm = 1'b1;
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        reached = 1'b0;
        for (int i = 0; i < 50 && !reached; i++) begin
            @(negedge Clk);
            reached = InstrReq && (PC == 8'h01);
        end
        chk("imm_req_reached", reached, 1'b1);
        repeat (3) @(negedge Clk);
        @(posedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        chk("mid_rst_pc", PC, 8'h00);
        chk("mid_rst_req", InstrReq, 1'b0);
        chk("mid_rst_halted", Halted, 1'b0);
        model_reset();
        stall_imm = 1'b0;
        @(negedge Clk);
        #2 Reset_n = 1'b1;
        wait_halt(500, "C");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
